// File: rtl/pll_reset_sequencer_pkg.sv
// pll_reset_sequencer_pkg: state encoding shared by the sequencer and any LED/debug decode of its state output
package pll_reset_sequencer_pkg;
  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } pll_state_e;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// sync_bit: STAGES-deep single-bit synchroniser with synchronous clear
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clock) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL start-up and SoC reset sequencing on the board clock.
// PLL_RETRY_EN adds the PLL_RST pulse state and a lock timeout that re-pulses the PLL.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 128,
  parameter int RESET_HOLD_CYCLES   = 128,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       reset_req,
  output logic       pll_rst,
  output logic       soc_reset,
  output logic [1:0] state,
  output logic [7:0] lock_loss_cnt
);
  localparam int CW = $clog2(max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES) + 1);
  pll_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] llc_q, llc_d;
  logic soc_reset_q, soc_reset_d;
  logic locked_s, qualified, timed_out;
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clock(clock),
    .reset(reset),
    .d(pll_locked),
    .q(locked_s)
  );
  assign qualified = locked_s && cnt_q == CW'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_RETRY_EN
  localparam pll_state_e RESET_STATE = PLL_RST;
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timeout_q, timeout_d;
  logic pll_rst_q, pll_rst_d;
  assign timed_out = timeout_q == TW'(LOCK_TIMEOUT_CYCLES - 1);
  always_comb begin
    timeout_d = (state_q == WAIT_LOCK && state_d == WAIT_LOCK) ? timeout_q + 1'b1 : '0;
    pll_rst_d = state_d == PLL_RST;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      timeout_q <= '0;
      pll_rst_q <= 1'b1;
    end else begin
      timeout_q <= timeout_d;
      pll_rst_q <= pll_rst_d;
    end
  end
  assign pll_rst = pll_rst_q;
`else
  localparam pll_state_e RESET_STATE = WAIT_LOCK;
  // no retry: WAIT_LOCK never times out, the timeout length only matters to the retry build
  assign timed_out = 1'b0 & (LOCK_TIMEOUT_CYCLES > 0);
  assign pll_rst   = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    llc_d   = llc_q;
    case (state_q)
      PLL_RST:   state_d = cnt_q == CW'(PLL_RST_CYCLES - 1) ? WAIT_LOCK : PLL_RST;
      WAIT_LOCK: state_d = qualified ? HOLD : timed_out ? PLL_RST : WAIT_LOCK;
      HOLD:      state_d = !locked_s ? WAIT_LOCK : cnt_q == CW'(RESET_HOLD_CYCLES - 1) ? RUN : HOLD;
      default: begin
        state_d = !locked_s ? WAIT_LOCK : reset_req ? HOLD : RUN;
        llc_d   = (!locked_s && llc_q != 8'hff) ? llc_q + 1'b1 : llc_q;
      end
    endcase
    // one counter serves every state: it restarts on any state change and on a lock drop in WAIT_LOCK
    cnt_d = (state_d != state_q || state_q == RUN || (state_q == WAIT_LOCK && !locked_s)) ? '0 : cnt_q + 1'b1;
    soc_reset_d = state_d != RUN;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      cnt_q       <= '0;
      llc_q       <= '0;
      soc_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      llc_q       <= llc_d;
      soc_reset_q <= soc_reset_d;
    end
  end
  assign state         = state_q;
  assign soc_reset     = soc_reset_q;
  assign lock_loss_cnt = llc_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: scoreboard bench with a phase/age reference model; honours PLL_RETRY_EN
module tb_pll_reset_sequencer;
  import pll_reset_sequencer_pkg::*;
  localparam int SS = 2, PR = 3, LS = 4, RH = 8, LT = 32;
`ifdef PLL_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  localparam int START = RETRY ? int'(PLL_RST) : int'(WAIT_LOCK);
  logic clock = 1'b0, reset = 1'b1, pll_locked = 1'b0, reset_req = 1'b0;
  logic pll_rst, soc_reset;
  logic [1:0] state;
  logic [7:0] lock_loss_cnt;
  pll_reset_sequencer #(
    .SYNC_STAGES(SS), .PLL_RST_CYCLES(PR), .LOCK_STABLE_CYCLES(LS),
    .RESET_HOLD_CYCLES(RH), .LOCK_TIMEOUT_CYCLES(LT)
  ) dut (
    .clock(clock), .reset(reset), .pll_locked(pll_locked), .reset_req(reset_req),
    .pll_rst(pll_rst), .soc_reset(soc_reset), .state(state), .lock_loss_cnt(lock_loss_cnt)
  );
  always #5 clock = ~clock;
  typedef struct packed {
    logic [1:0] st;
    logic       prst;
    logic       srst;
    logic [7:0] llc;
  } exp_t;
  exp_t expq[$];
  int total = 0, bad = 0;
  int ph, age, run, llc;
  int sq[$];
  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask
  // Reference: phase number, cycles spent in the phase, and the lock run seen during this visit.
  task automatic model_step();
    int nxt, ls;
    if (reset) begin
      ph = START; age = 0; run = 0; llc = 0;
      sq = {};
      for (int i = 0; i < SS; i++) sq.push_back(0);
    end else begin
      ls = sq.pop_front();
      sq.push_back(int'(pll_locked));
      age++;
      nxt = ph;
      if (ph == 0) nxt = age == PR ? 1 : 0;
      else if (ph == 1) begin
        run = ls ? run + 1 : 0;
        nxt = run == LS ? 2 : (RETRY && age == LT) ? 0 : 1;
      end else if (ph == 2) nxt = !ls ? 1 : age == RH ? 3 : 2;
      else begin
        nxt = !ls ? 1 : reset_req ? 2 : 3;
        if (!ls && llc < 255) llc++;
      end
      if (nxt != ph) begin age = 0; run = 0; end
      ph = nxt;
    end
    expq.push_back('{st: 2'(ph), prst: ph == 0, srst: ph != 3, llc: 8'(llc)});
  endtask
  always @(posedge clock) model_step();
  always @(negedge clock) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("state", int'(state), int'(e.st));
      chk("pll_rst", int'(pll_rst), int'(e.prst));
      chk("soc_reset", int'(soc_reset), int'(e.srst));
      chk("lock_loss_cnt", int'(lock_loss_cnt), int'(e.llc));
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic wait_state(input int s);
    int n = 0;
    while (int'(state) != s && n < 200) begin cyc(1); n++; end
    chk("wait_state", int'(state), s);
  endtask
  task automatic cycles_to_run(input string name, input int k0, input int want);
    int k = k0;
    do begin cyc(1); k++; end while (soc_reset !== 1'b0 && k < 100);
    chk(name, k, want);
  endtask
  initial begin
    int mode;
    cyc(3);
    reset = 1'b0;
    cyc(5);
    pll_locked = 1'b1;
    cycles_to_run("cold_start_latency", 0, SS + LS + RH);
    chk("cold_start_state", int'(state), int'(RUN));
    reset = 1'b1; pll_locked = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(5);
    pll_locked = 1'b1; cyc(3);
    pll_locked = 1'b0; cyc(1);
    pll_locked = 1'b1;
    cycles_to_run("glitch_latency", 0, SS + LS + RH);
    reset_req = 1'b1; cyc(1);
    reset_req = 1'b0;
    cycles_to_run("req_pulse_width", 1, 1 + RH);
    chk("req_pulse_llc", int'(lock_loss_cnt), 0);
    pll_locked = 1'b0; cyc(2);
    reset_req = 1'b1; cyc(1);
    reset_req = 1'b0; pll_locked = 1'b1;
    chk("simul_state", int'(state), int'(WAIT_LOCK));
    chk("simul_llc", int'(lock_loss_cnt), 1);
    wait_state(int'(HOLD));
    cyc(3);
    reset = 1'b1; cyc(1);
    reset = 1'b0;
    chk("hold_reset_state", int'(state), START);
    chk("hold_reset_soc", int'(soc_reset), 1);
    chk("hold_reset_llc", int'(lock_loss_cnt), 0);
    wait_state(int'(RUN));
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0; cyc(1);
      pll_locked = 1'b1; cyc(24);
    end
    chk("llc_saturated", int'(lock_loss_cnt), 255);
    for (int ep = 0; ep < 60; ep++) begin
      mode = int'($urandom_range(0, 3));
      repeat ($urandom_range(20, 90)) begin
        pll_locked = mode == 0 ? 1'b0 :
                     mode == 1 ? ($urandom_range(0, 7) != 0) :
                     mode == 2 ? 1'b1 : ($urandom_range(0, 63) != 0);
        reset_req  = mode == 2 ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 63) == 0);
        reset      = $urandom_range(0, 299) == 0;
        cyc(1);
      end
    end
    reset = 1'b0; reset_req = 1'b0; pll_locked = 1'b1;
    cyc(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
